usb_line_capture: RTL and testbench

USB_LINE_CAPTURE -- requirements
Module: usb_line_capture

---
 rtl/usb_line_capture_pkg.sv | 23 ++
 rtl/usb_line_capture_if.sv | 26 ++
 rtl/usb_line_capture_fifo.sv | 67 ++++++
 rtl/usb_line_capture.sv | 173 +++++++++++++++++
 tb/tb_usb_line_capture.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_line_capture_pkg.sv
// usb_cap_pkg: shared types and constants for the USB line capture block.
//   capState_e   : sampling FSM states
//   capEntry_t   : one FIFO entry {last, count, data}
//   SAMPLES_PER_BYTE, DEFAULT_FIFO_DEPTH, DEFAULT_FIFO_ADDR_WIDTH
package usb_cap_pkg;

    localparam int SAMPLES_PER_BYTE        = 4;
    localparam int DEFAULT_FIFO_DEPTH      = 16;
    localparam int DEFAULT_FIFO_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } capState_e;

    typedef struct packed {
        logic       last;
        logic [1:0] count;
        logic [7:0] data;
    } capEntry_t;

endpackage

// File: rtl/usb_line_capture_if.sv
// usb_cap_if: capture output stream (valid/ready with packed line samples).
//   master : producer side (drives data/count/last/valid, receives ready)
//   slave  : consumer side
interface usb_cap_if;
    logic [7:0] capData_o;
    logic [1:0] capCount_o;
    logic       capLast_o;
    logic       capValid_o;
    logic       capReady_i;

    modport master (
        output capData_o,
        output capCount_o,
        output capLast_o,
        output capValid_o,
        input  capReady_i
    );

    modport slave (
        input  capData_o,
        input  capCount_o,
        input  capLast_o,
        input  capValid_o,
        output capReady_i
    );
endinterface

// File: rtl/usb_line_capture_fifo.sv
// usb_cap_fifo: synchronous first-word-fall-through FIFO of capture entries.
//   clk_i, rst_i (async, active-low)
//   pushEn_i / pushData_i : write request; dropped when full and not popping
//   popReady_i            : consumer ready; pop = headValid_o & popReady_i
//   head_o / headValid_o  : current head entry (zero when empty)
//   drop_o                : a push was discarded this cycle
module usb_cap_fifo
    import usb_cap_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int AW    = DEFAULT_FIFO_ADDR_WIDTH
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      pushEn_i,
    input  capEntry_t pushData_i,
    input  logic      popReady_i,
    output capEntry_t head_o,
    output logic      headValid_o,
    output logic      drop_o
);

    capEntry_t       mem [DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [AW:0]     fill;
    logic            full;
    logic            pop;
    logic            wr;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (fill == (AW + 1)'(DEPTH));
    assign headValid_o = (fill != '0);
    assign pop         = headValid_o & popReady_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr          = pushEn_i & (~full | pop);
    assign drop_o      = pushEn_i & full & ~pop;
    assign head_o      = headValid_o ? mem[rdPtr] : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            fill  <= '0;
        end else begin
            if (wr) begin
                mem[wrPtr] <= pushData_i;
                wrPtr      <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({wr, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/usb_line_capture.sv
// usb_line_capture: captures driven USB line states {VP,VM} during bursts,
// packs four samples per byte (first sample in bits [1:0]) and queues the
// bytes in a FWFT FIFO with a burst-end marker.
//   clk_i, rst_i (async, active-low)
//   USBWireDataOut/USBWireDataOutTick/USBWireCtrlOut : line sample inputs
//   capBus (usb_cap_if.master) : capData_o, capCount_o, capLast_o,
//                                capValid_o, capReady_i
//   overflow_o / clrOverflow_i : sticky drop flag and its clear
// Optional build macro USB_CAP_DROP_CNT_EN adds dropCnt_o, a saturating
// count of dropped bytes.
//
// state     | meaning
// ST_IDLE   | ctrl low, no burst in progress
// ST_ACTIVE | ctrl high, samples being assembled
// ST_FLUSH  | second push of a burst end (partial byte after pending)
module usb_line_capture
    import usb_cap_pkg::*;
#(
    parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
    parameter int FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  USBWireDataOut,
    input  logic        USBWireDataOutTick,
    input  logic        USBWireCtrlOut,
    usb_cap_if.master   capBus,
    output logic        overflow_o,
    input  logic        clrOverflow_i
`ifdef USB_CAP_DROP_CNT_EN
    ,
    output logic [7:0]  dropCnt_o
`endif
);

    localparam logic [1:0] LAST_SLOT = 2'(SAMPLES_PER_BYTE - 1);

    capState_e  state;
    logic [7:0] asmReg;
    logic [1:0] sampleCnt;
    logic [7:0] pendReg;
    logic       pendValid;

    logic       sampleEn;
    logic       ctrlFall;
    logic       pushEn;
    capEntry_t  pushEntry;
    capEntry_t  head;
    logic       headValid;
    logic       drop;

    assign sampleEn = USBWireDataOutTick & USBWireCtrlOut;
    // ST_ACTIVE is only held while ctrl was high last cycle.
    assign ctrlFall = (state == ST_ACTIVE) & ~USBWireCtrlOut;

    always_comb begin
        pushEn    = 1'b0;
        pushEntry = '0;
        if (state == ST_FLUSH) begin
            pushEn          = 1'b1;
            pushEntry.last  = 1'b1;
            pushEntry.count = sampleCnt - 2'd1;
            pushEntry.data  = asmReg;
        end else if (ctrlFall) begin
            if (pendValid) begin
                pushEn          = 1'b1;
                pushEntry.last  = (sampleCnt == 2'd0);
                pushEntry.count = LAST_SLOT;
                pushEntry.data  = pendReg;
            end else if (sampleCnt != 2'd0) begin
                pushEn          = 1'b1;
                pushEntry.last  = 1'b1;
                pushEntry.count = sampleCnt - 2'd1;
                pushEntry.data  = asmReg;
            end
        end else if (sampleEn && pendValid) begin
            // Pending byte is only known not to be the last once another
            // sample arrives.
            pushEn          = 1'b1;
            pushEntry.last  = 1'b0;
            pushEntry.count = LAST_SLOT;
            pushEntry.data  = pendReg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            asmReg    <= '0;
            sampleCnt <= '0;
            pendReg   <= '0;
            pendValid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:   if (USBWireCtrlOut) state <= ST_ACTIVE;
                ST_ACTIVE: if (!USBWireCtrlOut)
                               state <= (pendValid && sampleCnt != 2'd0) ? ST_FLUSH : ST_IDLE;
                ST_FLUSH:  state <= USBWireCtrlOut ? ST_ACTIVE : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase

            if (state == ST_FLUSH) begin
                // Partial byte leaves now; a returning burst may already sample.
                asmReg    <= sampleEn ? {6'b0, USBWireDataOut} : '0;
                sampleCnt <= sampleEn ? 2'd1 : 2'd0;
            end else if (ctrlFall) begin
                pendValid <= 1'b0;
                if (!pendValid) begin
                    asmReg    <= '0;
                    sampleCnt <= '0;
                end
            end else if (sampleEn) begin
                pendValid <= 1'b0;
                if (sampleCnt == LAST_SLOT) begin
                    pendReg   <= {USBWireDataOut, asmReg[5:0]};
                    pendValid <= 1'b1;
                    asmReg    <= '0;
                    sampleCnt <= '0;
                end else begin
                    asmReg[{sampleCnt, 1'b0} +: 2] <= USBWireDataOut;
                    sampleCnt                      <= sampleCnt + 2'd1;
                end
            end
        end
    end

    usb_cap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pushEn_i    (pushEn),
        .pushData_i  (pushEntry),
        .popReady_i  (capBus.capReady_i),
        .head_o      (head),
        .headValid_o (headValid),
        .drop_o      (drop)
    );

    assign capBus.capData_o  = head.data;
    assign capBus.capCount_o = head.count;
    assign capBus.capLast_o  = head.last;
    assign capBus.capValid_o = headValid;

    // A drop in the same cycle as a clear wins so no loss goes unreported.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clrOverflow_i) begin
            overflow_o <= 1'b0;
        end
    end

`ifdef USB_CAP_DROP_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dropCnt_o <= '0;
        end else if (drop) begin
            if (clrOverflow_i) begin
                dropCnt_o <= 8'd1;
            end else if (dropCnt_o != 8'hFF) begin
                dropCnt_o <= dropCnt_o + 8'd1;
            end
        end else if (clrOverflow_i) begin
            dropCnt_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_usb_line_capture.sv
// Directed bench for usb_line_capture. Popped entries are collected as
// {last, count[1:0], data[7:0]} and compared with hand-computed values.
module tb_usb_line_capture;
    import usb_cap_pkg::*;

    logic       clk;
    logic       rstN;
    logic [1:0] wireData;
    logic       wireTick;
    logic       wireCtrl;
    logic       overflow;
    logic       clrOverflow;
`ifdef USB_CAP_DROP_CNT_EN
    logic [7:0] dropCnt;
`endif

    int passCnt  = 0;
    int totalCnt = 0;
    logic [10:0] capQ [$];

    usb_cap_if capIf ();

    usb_line_capture dut (
        .clk_i              (clk),
        .rst_i              (rstN),
        .USBWireDataOut     (wireData),
        .USBWireDataOutTick (wireTick),
        .USBWireCtrlOut     (wireCtrl),
        .capBus             (capIf.master),
        .overflow_o         (overflow),
        .clrOverflow_i      (clrOverflow)
`ifdef USB_CAP_DROP_CNT_EN
        ,
        .dropCnt_o          (dropCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstN && capIf.capValid_o && capIf.capReady_i)
            capQ.push_back({capIf.capLast_o, capIf.capCount_o, capIf.capData_o});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sampleLine(input logic [1:0] d);
        wireData = d;
        wireTick = 1'b1;
        cyc(1);
        wireTick = 1'b0;
    endtask

    task automatic expectByte(input string tag, input logic [10:0] exp);
        int n;
        n = 0;
        while (capQ.size() == 0 && n < 40) begin
            cyc(1);
            n++;
        end
        if (capQ.size() == 0) check({tag, "_timeout"}, capQ.size(), 1);
        else                  check(tag, {21'd0, capQ.pop_front()}, {21'd0, exp});
    endtask

    function automatic logic [10:0] headEntry();
        return {capIf.capLast_o, capIf.capCount_o, capIf.capData_o};
    endfunction

    initial begin
        rstN              = 1'b0;
        wireData          = 2'b00;
        wireTick          = 1'b0;
        wireCtrl          = 1'b0;
        clrOverflow       = 1'b0;
        capIf.capReady_i  = 1'b1;
        cyc(3);

        // Reset state
        check("rst_valid", capIf.capValid_o, 0);
        check("rst_data",  capIf.capData_o,  0);
        check("rst_count", capIf.capCount_o, 0);
        check("rst_last",  capIf.capLast_o,  0);
        check("rst_ovf",   overflow,         0);
        rstN = 1'b1;
        cyc(2);

        // Two full bytes, burst ends on a byte boundary
        wireCtrl = 1'b1;
        cyc(1);
        sampleLine(2'b01); sampleLine(2'b10); sampleLine(2'b01); sampleLine(2'b10);
        sampleLine(2'b00); sampleLine(2'b00); sampleLine(2'b11); sampleLine(2'b00);
        wireCtrl = 1'b0;
        cyc(4);
        expectByte("b8_first", 11'h399);
        expectByte("b8_last",  11'h730);
        check("b8_empty", capQ.size(), 0);

        // Five samples: full byte plus one-sample partial
        wireCtrl = 1'b1;
        cyc(1);
        repeat (5) sampleLine(2'b01);
        wireCtrl = 1'b0;
        cyc(4);
        expectByte("b5_full",    11'h355);
        expectByte("b5_partial", 11'h401);

        // Ticks while ctrl low capture nothing
        for (int i = 0; i < 4; i++) begin
            sampleLine(2'b11);
            check("idle_tick_valid", capIf.capValid_o, 0);
        end
        // Burst with no samples pushes nothing
        wireCtrl = 1'b1;
        cyc(3);
        wireCtrl = 1'b0;
        cyc(4);
        check("idle_none", capQ.size(), 0);

        // Push latency and hold while not ready
        capIf.capReady_i = 1'b0;
        wireCtrl = 1'b1;
        cyc(1);
        repeat (4) sampleLine(2'b10);
        wireData = 2'b11;
        wireTick = 1'b1;
        check("lat_before", capIf.capValid_o, 0);
        cyc(1);
        wireTick = 1'b0;
        check("lat_valid", capIf.capValid_o, 1);
        check("lat_head", headEntry(), 11'h3AA);
        cyc(3);
        check("hold_head", headEntry(), 11'h3AA);
        wireCtrl = 1'b0;
        cyc(2);
        capIf.capReady_i = 1'b1;
        expectByte("lat_full",    11'h3AA);
        expectByte("lat_partial", 11'h403);

        // Overflow: 16 bytes fill the FIFO, the 17th is dropped
        capIf.capReady_i = 1'b0;
        wireCtrl = 1'b1;
        cyc(1);
        for (int i = 0; i < 68; i++) sampleLine(2'((i / 4) % 4));
        check("ovf_before", overflow, 0);
        wireCtrl    = 1'b0;
        clrOverflow = 1'b1;
        cyc(1);
        clrOverflow = 1'b0;
        check("ovf_drop_vs_clr", overflow, 1);
        cyc(1);
        check("ovf_sticky", overflow, 1);
`ifdef USB_CAP_DROP_CNT_EN
        check("dropcnt_one", dropCnt, 1);
`endif
        check("ovf_head", headEntry(), 11'h300);
        clrOverflow = 1'b1;
        cyc(1);
        clrOverflow = 1'b0;
        check("ovf_cleared", overflow, 0);
`ifdef USB_CAP_DROP_CNT_EN
        check("dropcnt_cleared", dropCnt, 0);
`endif
        capIf.capReady_i = 1'b1;
        cyc(24);
        check("ovf_held", capQ.size(), 16);
        if (capQ.size() == 16) check("ovf_tail", {21'd0, capQ[15]}, 32'h3FF);
        capQ.delete();

        // Full FIFO with simultaneous pop: nothing dropped
        capIf.capReady_i = 1'b0;
        wireCtrl = 1'b1;
        cyc(1);
        for (int i = 0; i < 68; i++) sampleLine(2'((i / 4) % 4));
        wireCtrl = 1'b0;
        capIf.capReady_i = 1'b1;
        cyc(1);
        capIf.capReady_i = 1'b0;
        check("full_pop_ovf", overflow, 0);
        cyc(2);
        check("full_pop_ovf2", overflow, 0);
        capIf.capReady_i = 1'b1;
        cyc(24);
        check("full_pop_all", capQ.size(), 17);
        if (capQ.size() == 17) begin
            check("full_pop_first", {21'd0, capQ[0]},  32'h300);
            check("full_pop_last",  {21'd0, capQ[16]}, 32'h700);
        end
        capQ.delete();

        // Reset mid-burst discards partial data
        wireCtrl = 1'b1;
        cyc(1);
        repeat (3) sampleLine(2'b11);
        rstN = 1'b0;
        cyc(2);
        check("midrst_valid", capIf.capValid_o, 0);
        rstN = 1'b1;
        cyc(1);
        repeat (4) sampleLine(2'b10);
        wireCtrl = 1'b0;
        cyc(4);
        expectByte("midrst_byte", 11'h7AA);
        cyc(4);
        check("midrst_only", capQ.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
